// File: rtl/fir_driver.sv
// FIR filter driver: loads NUM_TAPS coefficients, then streams samples through one data port.
// Optional zero-sample flush is built only when FIR_DRIVER_ZERO_FLUSH_EN is defined.
module fir_driver #(
  parameter int NUM_TAPS   = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  reload,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] smp_data,
  input  logic                  smp_valid,
  output logic                  smp_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] fir_data,
  output logic                  fir_coef_enable,
  output logic                  fir_sample_enable,
  input  logic                  fir_error,
  output logic                  loaded,
  output logic                  err_flag,
  output logic [15:0]           sample_count
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, STREAM, ERROR} state_t;

  localparam logic [7:0] LAST_TAP = 8'(NUM_TAPS - 1);

  state_t     state, state_nxt;
  logic [7:0] coef_cnt;
  logic       cfg_hs, smp_hs, issue_zero, flush_block, load_entry;

`ifdef FIR_DRIVER_ZERO_FLUSH_EN
  logic [7:0] flush_left;
  logic       flush_busy, stream_ok, flush_start;

  assign flush_busy  = (flush_left != '0);
  assign stream_ok   = (state == STREAM) && !fir_error && !reload;
  assign flush_start = stream_ok && flush && !flush_busy;
  // The request cycle itself issues the first zero, so NUM_TAPS-1 remain afterwards.
  assign issue_zero  = stream_ok && (flush_busy || flush);
  assign flush_block = flush_busy || flush;

  always_ff @(posedge clk) begin
    if (reset || state_nxt != STREAM) flush_left <= '0;
    else if (flush_start)             flush_left <= LAST_TAP;
    else if (flush_busy && issue_zero) flush_left <= flush_left - 8'd1;
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign issue_zero   = 1'b0;
  assign flush_block  = 1'b0;
`endif

  assign cfg_ready = (state == LOAD);
  assign smp_ready = (state == STREAM) && !fir_error && !reload && !flush_block;
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign smp_hs    = smp_valid && smp_ready;
  assign loaded    = (state == STREAM);
  assign err_flag  = (state == ERROR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (cfg_hs && coef_cnt == LAST_TAP) state_nxt = GAP;
      GAP:     state_nxt = STREAM;
      STREAM: begin
        if (reload)         state_nxt = LOAD;
        else if (fir_error) state_nxt = ERROR;
      end
      ERROR:   if (reload) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  assign load_entry = (state_nxt == LOAD) && (state != LOAD);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fir_data          <= '0;
      fir_coef_enable   <= 1'b0;
      fir_sample_enable <= 1'b0;
      coef_cnt          <= '0;
      sample_count      <= '0;
    end else begin
      fir_coef_enable   <= cfg_hs;
      fir_sample_enable <= smp_hs || issue_zero;
      if (cfg_hs)          fir_data <= cfg_data;
      else if (smp_hs)     fir_data <= smp_data;
      else if (issue_zero) fir_data <= '0;

      if (load_entry)  coef_cnt <= '0;
      else if (cfg_hs) coef_cnt <= (coef_cnt == LAST_TAP) ? '0 : coef_cnt + 8'd1;

      if (load_entry)                sample_count <= '0;
      else if (smp_hs || issue_zero) sample_count <= sample_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_driver.sv
// Self-checking bench for fir_driver against a cycle-level behavioural model.
module tb_fir_driver;
  localparam int NUM_TAPS   = 5;
  localparam int DATA_WIDTH = 8;
`ifdef FIR_DRIVER_ZERO_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, reload, cfg_valid, smp_valid, flush, fir_error;
  logic [DATA_WIDTH-1:0] cfg_data, smp_data, fir_data;
  logic cfg_ready, smp_ready, fir_coef_enable, fir_sample_enable, loaded, err_flag;
  logic [15:0] sample_count;

  int checks = 0, failures = 0;
  int n_coef = 0, n_smp = 0, n_zero = 0;

  // reference model
  bit   m_idle, m_loading, m_gap, m_stream, m_err;
  int   taps_got, flush_left, m_count;
  logic [DATA_WIDTH-1:0] m_data;
  bit   m_coef_en, m_smp_en;

  fir_driver #(.NUM_TAPS(NUM_TAPS), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .reload(reload),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .flush(flush), .fir_data(fir_data), .fir_coef_enable(fir_coef_enable),
    .fir_sample_enable(fir_sample_enable), .fir_error(fir_error),
    .loaded(loaded), .err_flag(err_flag), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go_load();
    m_idle = 0; m_loading = 1; m_gap = 0; m_stream = 0; m_err = 0;
    taps_got = 0; m_count = 0; flush_left = 0;
  endtask

  task automatic step();
    bit exp_smp_ready;
    #1;
    if (!reset) begin
      exp_smp_ready = m_stream && !fir_error && !reload && flush_left == 0 && !(FLUSH_EN && flush);
      chk("cfg_ready", cfg_ready, m_loading);
      chk("smp_ready", smp_ready, exp_smp_ready);
    end
    if (reset) begin
      m_idle = 1; m_loading = 0; m_gap = 0; m_stream = 0; m_err = 0;
      taps_got = 0; flush_left = 0; m_count = 0; m_data = '0;
      m_coef_en = 0; m_smp_en = 0;
    end else begin
      m_coef_en = m_loading && cfg_valid;
      m_smp_en  = 0;
      if (m_coef_en) begin m_data = cfg_data; taps_got++; end
      if (m_stream && !fir_error && !reload) begin
        if (flush_left > 0) begin
          m_smp_en = 1; m_data = '0; flush_left--;
        end else if (FLUSH_EN && flush) begin
          m_smp_en = 1; m_data = '0; flush_left = NUM_TAPS - 1;
        end else if (smp_valid) begin
          m_smp_en = 1; m_data = smp_data;
        end
      end
      if (m_smp_en) m_count = (m_count + 1) % 65536;
      if (m_idle && start) go_load();
      else if (m_loading && taps_got == NUM_TAPS) begin m_loading = 0; m_gap = 1; end
      else if (m_gap) begin m_gap = 0; m_stream = 1; end
      else if ((m_stream || m_err) && reload) go_load();
      else if (m_stream && fir_error) begin m_stream = 0; m_err = 1; flush_left = 0; end
    end
    @(posedge clk); #1;
    chk("fir_data", fir_data, m_data);
    chk("coef_en", fir_coef_enable, m_coef_en);
    chk("smp_en", fir_sample_enable, m_smp_en);
    chk("loaded", loaded, m_stream);
    chk("err_flag", err_flag, m_err);
    chk("sample_count", sample_count, m_count[15:0]);
    chk("en_exclusive", fir_coef_enable & fir_sample_enable, 1'b0);
    if (fir_coef_enable) n_coef++;
    if (fir_sample_enable) n_smp++;
    if (fir_sample_enable && fir_data == '0) n_zero++;
  endtask

  task automatic load_random(input bit noise);
    int n = 0;
    while (!m_stream && n < 200) begin
      cfg_valid = ($urandom % 4) != 0;
      cfg_data  = DATA_WIDTH'($urandom);
      reload    = noise && ($urandom % 5 == 0);
      start     = noise && ($urandom % 5 == 0);
      step();
      n++;
    end
    cfg_valid = 0; reload = 0; start = 0;
    chk("load_done", loaded, 1'b1);
  endtask

  task automatic stream_random(input int cycles);
    repeat (cycles) begin
      smp_valid = ($urandom % 3) != 0;
      smp_data  = DATA_WIDTH'($urandom);
      flush     = ($urandom % 16) == 0;
      start     = ($urandom % 8) == 0;
      cfg_valid = $urandom % 2;
      step();
    end
    smp_valid = 0; flush = 0; start = 0; cfg_valid = 0;
  endtask

  initial begin
    reset = 1; start = 0; reload = 0; cfg_valid = 0; smp_valid = 0;
    flush = 0; fir_error = 0; cfg_data = '0; smp_data = '0;
    @(posedge clk); #1;
    step(); step();
    reset = 0;
    chk("rst_fir_data", fir_data, 0);
    chk("rst_count", sample_count, 0);

    // back-to-back coefficient load 4..8, extra cfg_valid in GAP is ignored
    start = 1; step(); start = 0;
    n_coef = 0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      cfg_valid = 1; cfg_data = DATA_WIDTH'(4 + i); step();
    end
    cfg_data = 8'hAA; step(); cfg_valid = 0;
    chk("coef_pulses", n_coef, NUM_TAPS);
    chk("last_coef_held", fir_data, 8);

    // five samples of value 1
    n_smp = 0; smp_data = 1; smp_valid = 1;
    repeat (5) step();
    smp_valid = 0; step();
    chk("smp_pulses", n_smp, 5);
    chk("count5", sample_count, 5);

    stream_random(80);

    // reload beats a coinciding sample
    smp_valid = 1; reload = 1; step();
    reload = 0; smp_valid = 0;
    chk("reload_count", sample_count, 0);
    chk("reload_cfg_ready", cfg_ready, 1);
    load_random(1'b1);
    stream_random(20);

    // error blocks the coinciding sample and holds enables low
    smp_valid = 1; fir_error = 1; step();
    fir_error = 0;
    chk("err_flag_set", err_flag, 1);
    n_smp = 0;
    repeat (6) begin
      smp_valid = $urandom % 2; flush = $urandom % 2; start = $urandom % 2; step();
    end
    smp_valid = 0; flush = 0; start = 0;
    chk("err_no_samples", n_smp, 0);
    reload = 1; step(); reload = 0;
    load_random(1'b0);
    stream_random(10);

    // reset mid-stream, then reset mid-load: a fresh full load is required
    reset = 1; step(); reset = 0;
    chk("rst_loaded", loaded, 0);
    chk("rst_err", err_flag, 0);
    start = 1; step(); start = 0;
    cfg_valid = 1; cfg_data = 8'h11; step(); step(); cfg_valid = 0;
    reset = 1; step(); reset = 0;
    chk("rst_mid_load_cfg_ready", cfg_ready, 0);
    start = 1; step(); start = 0;
    load_random(1'b0);

    // sample counter wrap
    smp_valid = 1;
    repeat (65535) begin smp_data = DATA_WIDTH'($urandom); step(); end
    chk("count_ffff", sample_count, 16'hFFFF);
    step();
    chk("count_wrap", sample_count, 0);
    smp_valid = 0; step();

    // flush: zero samples only when the feature is built in
    n_zero = 0; smp_data = 8'h5A; smp_valid = 1; flush = 1; step();
    flush = 0;
    repeat (NUM_TAPS) step();
    smp_valid = 0; step();
    chk("flush_zeros", n_zero, FLUSH_EN ? NUM_TAPS : 0);
    chk("flush_resume", smp_ready, 1);

    // error aborts an active flush
    flush = 1; step(); flush = 0; step();
    fir_error = 1; step(); fir_error = 0;
    chk("flush_err", err_flag, 1);
    step();
    chk("flush_err_quiet", fir_sample_enable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_driver.md
FIR_DRIVER -- requirements
Module: fir_driver

Interface
REQ-001 Parameter: NUM_TAPS, default 5, number of coefficients loaded per configuration (2..255).
REQ-002 Parameter: DATA_WIDTH, default 8, width of coefficients and samples sent to the filter.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to begin coefficient loading from IDLE.
REQ-006 Port: reload  input  1  one-cycle request to restart coefficient loading from STREAM or ERROR.
REQ-007 Port: cfg_data, cfg_valid / cfg_ready  input DATA_WIDTH, input 1 / output 1  coefficient stream with valid/ready handshake.
REQ-008 Port: smp_data, smp_valid / smp_ready  input DATA_WIDTH, input 1 / output 1  sample stream with valid/ready handshake.
REQ-009 Port: flush  input  1  one-cycle request to inject zero samples; used only when FIR_DRIVER_ZERO_FLUSH_EN is defined.
REQ-010 Port: fir_data  output  DATA_WIDTH  registered word driven to the filter's data input.
REQ-011 Port: fir_coef_enable, fir_sample_enable  output 1 each  registered filter enables; never both high.
REQ-012 Port: fir_error  input  1  filter error flag.
REQ-013 Port: loaded, err_flag  output 1 each  high in STREAM and in ERROR respectively.
REQ-014 Port: sample_count  output  16  number of samples issued to the filter since the last load.

Function
REQ-015 States SHALL be IDLE, LOAD, GAP, STREAM, ERROR; IDLE->LOAD on start; LOAD->GAP after the NUM_TAPS-th coefficient handshake; GAP->STREAM after exactly one cycle; STREAM->ERROR when fir_error=1; STREAM or ERROR->LOAD on reload.
REQ-016 cfg_ready SHALL be 1 only in LOAD, combinationally from state.
REQ-017 A cfg handshake at edge N SHALL give fir_data=cfg_data and fir_coef_enable=1 during cycle N+1 (latency 1); otherwise fir_coef_enable=0.
REQ-018 The coefficient counter SHALL count 0..NUM_TAPS-1, cleared on entry to LOAD; extra cfg_valid after the last coefficient SHALL be ignored (cfg_ready=0).
REQ-019 In GAP, both enables SHALL be 0 and fir_data SHALL hold.
REQ-020 smp_ready SHALL equal (state==STREAM) AND NOT fir_error AND NOT reload.
REQ-021 A sample handshake at edge N SHALL give fir_data=smp_data and fir_sample_enable=1 during cycle N+1; cycles without a handshake SHALL drive fir_sample_enable=0 with fir_data held.
REQ-022 sample_count SHALL increment per issued sample, wrap 0xFFFF->0x0000, and clear on entry to LOAD.
REQ-023 reload coinciding with smp_valid SHALL win: no sample accepted, next state LOAD.
REQ-024 fir_error coinciding with smp_valid in STREAM SHALL block the sample; ERROR SHALL hold enables 0 until reset or reload.
REQ-025 start outside IDLE and reload in IDLE, LOAD or GAP SHALL be ignored.

Reset
REQ-026 On reset: state=IDLE; fir_data=0; fir_coef_enable=0; fir_sample_enable=0; loaded=0; err_flag=0; sample_count=0; counters=0.
REQ-027 Reset mid-LOAD or mid-STREAM SHALL abort immediately; partial coefficient loads SHALL NOT be resumed.

Configuration
REQ-028 With FIR_DRIVER_ZERO_FLUSH_EN defined, flush in STREAM SHALL deassert smp_ready and issue NUM_TAPS consecutive samples of value 0 (fir_sample_enable=1 each cycle, counted in sample_count), then resume normal STREAM; flush during an active flush SHALL be ignored; fir_error SHALL abort the flush into ERROR.
REQ-029 Without FIR_DRIVER_ZERO_FLUSH_EN, flush SHALL have no effect and no flush logic SHALL be synthesized.

Verification
REQ-030 reset, start, cfg 4,5,6,7,8 back-to-back -> fir_coef_enable high 5 cycles with fir_data 4,5,6,7,8; one GAP cycle with both enables 0; loaded=1.
REQ-031 STREAM, smp_data=1 valid 5 cycles -> fir_sample_enable high 5 cycles one cycle later, fir_data=1, sample_count=5.
REQ-032 STREAM, reload and smp_valid same cycle -> smp_ready=0, no sample issued, state LOAD, sample_count=0, cfg_ready=1 next cycle.
REQ-033 STREAM, fir_error=1 -> err_flag=1 next cycle, smp_ready=0, enables 0 until reload; reset -> all outputs at reset values.
REQ-034 sample_count preset path: 65536 samples -> sample_count wraps to 0.
REQ-035 With FIR_DRIVER_ZERO_FLUSH_EN, flush in STREAM -> 5 cycles fir_sample_enable=1, fir_data=0, smp_ready=0, then smp_ready=1; without macro -> no change.
